shift_add_mul_ctrl: RTL and testbench

Sequential unsigned shift-and-add multiplier controller and datapath. It sits directly upstream of the 16-bit ripple-carry adder and drives both adder operands each cycle. It consumes the adder's sum and carry-out, and accumulates the partial product over WIDTH iterations. It delivers a 2*WIDTH-bit product with a start/busy/done handshake.

---
 rtl/mul_pkg.sv | 34 +++
 rtl/mul_fsm.sv | 112 +++++++++++
 rtl/shift_add_mul_ctrl.sv | 124 ++++++++++++
 tb/tb_shift_add_mul_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : mul_pkg
//  Description : Shared types and sizing helpers for the shift-and-add
//                multiplier controller (state encoding, default operand
//                width, product/counter width derivation).
//  Revision    : 1.0 - initial release
// ============================================================================
package mul_pkg;

    // Default operand width; product and adder ports are twice this
    localparam int C_DEF_WIDTH = 8;

    // Product / accumulator / adder-port width for a given operand width
    function automatic int prod_w(input int width);
        return 2 * width;
    endfunction

    // Iteration counter width: must be able to hold the value WIDTH
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int C_PROD_W = 2 * C_DEF_WIDTH;
    localparam int C_CNT_W  = $clog2(C_DEF_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : mul_pkg
`default_nettype wire

// File: rtl/mul_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : mul_fsm
//  Description : Sequencer for the shift-and-add multiplier. Owns the state
//                register and the iteration counter, and produces the
//                load/finish strobes consumed by the datapath plus the
//                busy/done handshake.
//                Optional build macro: EARLY_TERM_EN (stop iterating once the
//                remaining multiplier bits are all zero).
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_fsm
    import mul_pkg::*;
#(
    parameter int WIDTH = C_DEF_WIDTH
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   i_start,
    input  logic   i_b_zero,            // multiplier operand on the bus is zero
    input  logic   i_mplier_next_zero,  // multiplier register after this shift is zero
    output state_t o_state,
    output logic   o_load,              // start accepted: datapath loads operands
    output logic   o_finish,            // last iteration: datapath captures product
    output logic   o_busy,
    output logic   o_done
);

    localparam int CNT_W = cnt_w(WIDTH);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             w_last;
    logic             w_load;
    logic             w_finish;

    // Last-iteration detect: fixed count, optionally cut short once no
    // multiplier bits remain to be accumulated
    always_comb begin
        w_last = (r_cnt == CNT_W'(WIDTH - 1));
`ifdef EARLY_TERM_EN
        w_last = w_last | i_mplier_next_zero;
`endif
    end

`ifndef EARLY_TERM_EN
    // Zero-detect inputs only matter when early termination is built in
    logic w_unused;
    assign w_unused = i_b_zero ^ i_mplier_next_zero;
`endif

    // Next-state and strobe decode
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_load      = 1'b1;
                    w_state_nxt = RUN;
`ifdef EARLY_TERM_EN
                    if (i_b_zero) begin
                        w_state_nxt = DONE;
                    end
`endif
                end
            end
            RUN: begin
                if (w_last) begin
                    w_finish    = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Iteration counter: cleared on load, advances once per RUN cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_load) begin
            r_cnt <= '0;
        end else if (r_state == RUN) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_state  = r_state;
    assign o_load   = w_load;
    assign o_finish = w_finish;
    assign o_busy   = (r_state == RUN) || (r_state == DONE);
    assign o_done   = (r_state == DONE);

endmodule : mul_fsm
`default_nettype wire

// File: rtl/shift_add_mul_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : shift_add_mul_ctrl
//  Description : Sequential unsigned shift-and-add multiplier. Holds the
//                accumulator and shifted operand registers and drives an
//                external 2*WIDTH-bit adder (add_x + add_y -> add_z) once per
//                iteration. Start/busy/done handshake, sticky adder
//                carry-out error flag.
//                Optional build macro: EARLY_TERM_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_add_mul_ctrl
    import mul_pkg::*;
#(
    parameter int WIDTH = C_DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [2*WIDTH-1:0]   add_x,
    output logic [2*WIDTH-1:0]   add_y,
    input  logic [2*WIDTH-1:0]   add_z,
    input  logic                 add_ofs,
    output logic                 ovf_err
);

    localparam int PROD_W = prod_w(WIDTH);

    logic [PROD_W-1:0] r_acc;
    logic [PROD_W-1:0] r_mcand;
    logic [WIDTH-1:0]  r_mplier;
    logic [PROD_W-1:0] r_product;
    logic              r_ovf_err;

    state_t            w_state;
    logic              w_load;
    logic              w_finish;
    logic              w_run;
    logic              w_b_zero;
    logic              w_mplier_next_zero;

    assign w_b_zero           = (b == '0);
    assign w_mplier_next_zero = ((r_mplier >> 1) == '0);
    assign w_run              = (w_state == RUN);

    mul_fsm #(
        .WIDTH (WIDTH)
    ) u_fsm (
        .clk                (clk),
        .rst                (rst),
        .i_start            (start),
        .i_b_zero           (w_b_zero),
        .i_mplier_next_zero (w_mplier_next_zero),
        .o_state            (w_state),
        .o_load             (w_load),
        .o_finish           (w_finish),
        .o_busy             (busy),
        .o_done             (done)
    );

    // Operand registers: load on accepted start, shift once per iteration
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (w_load) begin
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= b;
        end else if (w_run) begin
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
        end
    end

    // Accumulator takes the adder sum every iteration
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (w_load) begin
            r_acc <= '0;
        end else if (w_run) begin
            r_acc <= add_z;
        end
    end

    // Product register: captured on the last iteration, held otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            r_product <= '0;
        end else if (w_load) begin
`ifdef EARLY_TERM_EN
            // A zero multiplier skips RUN entirely, so the result is set here
            if (w_b_zero) begin
                r_product <= '0;
            end
`endif
        end else if (w_finish) begin
            r_product <= add_z;
        end
    end

    // Sticky carry-out flag; a correct adder never carries for in-range operands
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_err <= 1'b0;
        end else if (w_load) begin
            r_ovf_err <= 1'b0;
        end else if (w_run && add_ofs) begin
            r_ovf_err <= 1'b1;
        end
    end

    assign add_x   = w_run ? r_acc : '0;
    assign add_y   = (w_run && r_mplier[0]) ? r_mcand : '0;
    assign product = r_product;
    assign ovf_err = r_ovf_err;

endmodule : shift_add_mul_ctrl
`default_nettype wire

// File: tb/tb_shift_add_mul_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_add_mul_ctrl
//  Description : Self-checking bench for shift_add_mul_ctrl with a behavioural
//                adder, vector table, scoreboard queue and hand-written
//                sequences for busy-start, mid-run reset, carry injection and
//                back-to-back restart.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_add_mul_ctrl;

    localparam int W = 8;
    localparam int P = 2 * W;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [P-1:0] product;
    logic [P-1:0] add_x;
    logic [P-1:0] add_y;
    logic [P-1:0] add_z;
    logic         add_ofs;
    logic         ovf_err;
    logic         inj;
    logic [P:0]   w_sum;

    shift_add_mul_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product),
        .add_x   (add_x),
        .add_y   (add_y),
        .add_z   (add_z),
        .add_ofs (add_ofs),
        .ovf_err (ovf_err)
    );

    // Behavioural ripple adder with a carry-out injection hook
    assign w_sum   = {1'b0, add_x} + {1'b0, add_y};
    assign add_z   = w_sum[P-1:0];
    assign add_ofs = w_sum[P] | inj;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [P-1:0] prod;
    } vec_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [P-1:0] prod;
        int           lat;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[9];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Cycle in which done is expected, counting the start-driving cycle as 0
    function automatic int exp_lat(input logic [W-1:0] bv);
`ifdef EARLY_TERM_EN
        for (int i = W - 1; i >= 0; i--) begin
            if (bv[i]) return i + 2;
        end
        return 1;
`else
        return W + 1;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [P-1:0] pv, input logic ov, input bit push);
        exp_t e;
        cyc   = 0;
        start = 1'b1;
        a     = av;
        b     = bv;
        if (push) begin
            e.a = av; e.b = bv; e.prod = pv; e.lat = exp_lat(bv); e.ovf = ov;
            sb.push_back(e);
        end
    endtask

    // Step through one multiply, checking adder operands each iteration and
    // the scoreboard entry when done appears
    task automatic collect(input bit hold, input int inj_cyc, input int ign_from, input int ign_to);
        exp_t         e;
        bit           seen;
        int           k;
        logic [P-1:0] ex;
        logic [P-1:0] ey;
        logic [W-1:0] mask;
        seen = 1'b0;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 64'(1), 64'(0));
            return;
        end
        e = sb[0];
        for (int t = 0; t < 40 && !seen; t++) begin
            step();
            if (cyc == 1 && !hold) start = 1'b0;
            if (cyc == ign_from) begin start = 1'b1; a = 8'hFF; b = 8'hFF; end
            if (cyc == ign_to + 1) start = 1'b0;
            inj = (cyc == inj_cyc);
            if (done) begin
                seen = 1'b1;
                e = sb.pop_front();
                check("done_cycle",   64'(cyc),     64'(e.lat));
                check("product",      64'(product), 64'(e.prod));
                check("ovf_err",      64'(ovf_err), 64'(e.ovf));
                check("busy_in_done", 64'(busy),    64'(1));
                check("ops_in_done",  64'({add_x, add_y}), 64'(0));
            end else begin
                k    = cyc - 1;
                mask = W'((1 << k) - 1);
                ex   = P'({{W{1'b0}}, e.a} * {{W{1'b0}}, e.b & mask});
                ey   = ((e.b >> k) & 1) != 0 ? P'({{W{1'b0}}, e.a} << k) : '0;
                check("busy_run", 64'(busy),  64'(1));
                check("add_x",    64'(add_x), 64'(ex));
                check("add_y",    64'(add_y), 64'(ey));
            end
        end
        inj = 1'b0;
        if (!seen) begin
            check("done_timeout", 64'(0), 64'(1));
            void'(sb.pop_front());
        end
        if (!hold) begin
            step();
            check("done_one_pulse", 64'(done),    64'(0));
            check("idle_busy",      64'(busy),    64'(0));
            check("product_held",   64'(product), 64'(e.prod));
        end
    endtask

    initial begin
        int ndone;
        vecs[0] = '{8'h0F, 8'h0F, 16'h00E1};
        vecs[1] = '{8'hFF, 8'hFF, 16'hFE01};
        vecs[2] = '{8'h00, 8'h55, 16'h0000};
        vecs[3] = '{8'h07, 8'h01, 16'h0007};
        vecs[4] = '{8'h07, 8'h00, 16'h0000};
        vecs[5] = '{8'hA5, 8'h5A, 16'h3A02};
        vecs[6] = '{8'h80, 8'h80, 16'h4000};
        vecs[7] = '{8'h01, 8'hFF, 16'h00FF};
        vecs[8] = '{8'hFF, 8'h80, 16'h7F80};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; inj = 1'b0;
        repeat (2) step();
        check("rst_busy",    64'(busy),    64'(0));
        check("rst_done",    64'(done),    64'(0));
        check("rst_product", 64'(product), 64'(0));
        check("rst_add_x",   64'(add_x),   64'(0));
        check("rst_add_y",   64'(add_y),   64'(0));
        check("rst_ovf",     64'(ovf_err), 64'(0));
        rst = 1'b0;
        step();

        // Table-driven vectors
        for (int i = 0; i < 9; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].prod, 1'b0, 1'b1);
            collect(1'b0, -1, -1, -1);
        end

        // Start re-asserted (with new operands) while busy is ignored
        issue(8'h12, 8'h34, 16'h03A8, 1'b0, 1'b1);
        collect(1'b0, -1, 3, 5);
        ndone = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (done || busy) ndone++;
        end
        check("busy_start_ignored", 64'(ndone), 64'(0));

        // Reset in the middle of a multiply aborts without done
        issue(8'hAB, 8'hCD, 16'h0000, 1'b0, 1'b0);
        step();
        start = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        check("midrst_busy",    64'(busy),    64'(0));
        check("midrst_done",    64'(done),    64'(0));
        check("midrst_product", 64'(product), 64'(0));
        check("midrst_ops",     64'({add_x, add_y}), 64'(0));
        check("midrst_ovf",     64'(ovf_err), 64'(0));
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done) ndone++;
        end
        check("midrst_no_done", 64'(ndone), 64'(0));
        issue(8'h02, 8'h03, 16'h0006, 1'b0, 1'b1);
        collect(1'b0, -1, -1, -1);

        // Injected carry-out sets a sticky flag, cleared by the next start
        issue(8'h5A, 8'hC3, 16'h448E, 1'b1, 1'b1);
        collect(1'b0, 3, -1, -1);
        repeat (3) step();
        check("ovf_sticky_idle", 64'(ovf_err), 64'(1));
        issue(8'h0F, 8'h0F, 16'h00E1, 1'b0, 1'b1);
        step();
        start = 1'b0;
        check("ovf_cleared", 64'(ovf_err), 64'(0));
        cyc = 1;
        sb.pop_front();
        sb.push_front('{a: 8'h0F, b: 8'h0F, prod: 16'h00E1, lat: exp_lat(8'h0F), ovf: 1'b0});
        begin
            // Finish that multiply, continuing the cycle count from cycle 1
            int guard;
            guard = 0;
            while (!done && guard < 40) begin step(); guard++; end
            check("ovf_clear_product", 64'(product), 64'(16'h00E1));
            check("ovf_clear_cycle",   64'(cyc),     64'(exp_lat(8'h0F)));
            void'(sb.pop_front());
            step();
        end

        // Start held high restarts right after the IDLE cycle
        issue(8'h03, 8'h05, 16'h000F, 1'b0, 1'b1);
        collect(1'b1, -1, -1, -1);
        step();
        check("restart_idle_busy", 64'(busy), 64'(0));
        check("restart_idle_done", 64'(done), 64'(0));
        cyc = 0;
        sb.push_back('{a: 8'h03, b: 8'h05, prod: 16'h000F, lat: exp_lat(8'h05), ovf: 1'b0});
        collect(1'b0, -1, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_shift_add_mul_ctrl
`default_nettype wire
